// File: rtl/movegen_sequencer.sv
// Sequencer for the move-generation array: clear, propagate for a fixed time,
// then scan every (square, direction) word and stream the non-zero ones out.
module movegen_sequencer #(
  parameter  int PROP_CYCLES = 8,
  parameter  int NUM_SQ      = 64,
  parameter  int NUM_DIR     = 16,
  localparam int SQ_W        = (NUM_SQ  > 1) ? $clog2(NUM_SQ)  : 1,
  localparam int DIR_W       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             engine_color,
  output logic             sq_clear,
  output logic             sq_enable,
  output logic             sq_color,
  output logic [SQ_W-1:0]  scan_sq,
  output logic [DIR_W-1:0] scan_dir,
  input  logic [31:0]      scan_move,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [31:0]      mv_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       move_count
);

  localparam int PC_W = (PROP_CYCLES > 1) ? $clog2(PROP_CYCLES) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PROP_CYCLES - 1);
  localparam logic [SQ_W-1:0]  SQ_LAST  = SQ_W'(NUM_SQ - 1);
  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(NUM_DIR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PROP, S_SCAN, S_FLUSH, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] prop_cnt;
  logic            kill, take, move_nz, slot_free, load, step, at_last, prop_end;

  assign kill      = abort && (state != S_IDLE);
  assign take      = (state == S_IDLE) && start;
  assign move_nz   = (scan_move != 32'd0);
  assign slot_free = !mv_valid || mv_ready;
  // abort wins over a load in the same cycle so move_count holds on abort
  assign load      = (state == S_SCAN) && move_nz && slot_free && !abort;
  assign step      = (state == S_SCAN) && (!move_nz || slot_free) && !abort;
  assign at_last   = (scan_sq == SQ_LAST) && (scan_dir == DIR_LAST);
  assign prop_end  = (state == S_PROP) && (prop_cnt == PC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sq_clear  = 1'b0;
    sq_enable = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        sq_clear  = 1'b1;
        state_nxt = S_PROP;
      end
      S_PROP: begin
        sq_enable = 1'b1;
        if (prop_cnt == PC_LAST) state_nxt = S_SCAN;
      end
      S_SCAN:  if (step && at_last) state_nxt = S_FLUSH;
      S_FLUSH: if (slot_free) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prop_cnt   <= '0;
      sq_color   <= 1'b0;
      move_count <= 8'd0;
      scan_sq    <= '0;
      scan_dir   <= '0;
      mv_valid   <= 1'b0;
      mv_data    <= 32'd0;
    end else begin
      if (state == S_PROP && !prop_end) prop_cnt <= prop_cnt + PC_W'(1);
      else                              prop_cnt <= '0;

      if (take) begin
        sq_color   <= engine_color;
        move_count <= 8'd0;
      end else if (load && move_count != 8'hFF) begin
        move_count <= move_count + 8'd1;
      end

      if (prop_end) begin
        scan_sq  <= '0;
        scan_dir <= '0;
      end else if (step && !at_last) begin
        if (scan_dir == DIR_LAST) begin
          scan_dir <= '0;
          scan_sq  <= scan_sq + SQ_W'(1);
        end else begin
          scan_dir <= scan_dir + DIR_W'(1);
        end
      end

      if (kill)          mv_valid <= 1'b0;
      else if (load)     mv_valid <= 1'b1;
      else if (mv_ready) mv_valid <= 1'b0;

      if (load) mv_data <= scan_move;
    end
  end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Scenario bench for movegen_sequencer: a board table feeds scan_move and a
// transaction-level model predicts the emitted stream and the done cycle.
module tb_movegen_sequencer;
  localparam int P    = 8;
  localparam int NSQ  = 64;
  localparam int NDIR = 16;
  localparam int NW   = NSQ * NDIR;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic rst, start, abort, engine_color, mv_ready;
  logic sq_clear, sq_enable, sq_color, mv_valid, busy, done;
  logic [5:0]  scan_sq;
  logic [3:0]  scan_dir;
  logic [31:0] scan_move, mv_data;
  logic [7:0]  move_count;

  logic [31:0] board [NW];
  bit          rdy_tab [4096];

  always #5 clk = ~clk;

  assign scan_move = board[{scan_sq, scan_dir}];

  movegen_sequencer #(.PROP_CYCLES(P), .NUM_SQ(NSQ), .NUM_DIR(NDIR)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .engine_color(engine_color),
    .sq_clear(sq_clear), .sq_enable(sq_enable), .sq_color(sq_color),
    .scan_sq(scan_sq), .scan_dir(scan_dir), .scan_move(scan_move),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_data(mv_data),
    .busy(busy), .done(done), .move_count(move_count)
  );

  int tests = 0;
  int fails = 0;

  // observations of one pass
  int          clear_cnt, clear_first, en_cnt, en_first, done_cnt, done_cyc, stab_viol, end_n;
  logic        abort_vld;
  logic [62:0] rst_snap;
  logic [31:0] xfers[$];

  // model results
  logic [31:0] exp_q[$];
  int          exp_done, exp_loads;

  function automatic bit ready_of(input int mode, input int n);
    case (mode)
      1:       return (n % 2) == 0;
      2:       return !(n >= 1034 && n < 1054);
      3:       return rdy_tab[n % 4096];
      default: return 1'b1;
    endcase
  endfunction

  // Walks the board in scan order with a one-entry output slot.
  task automatic model_pass(input int mode);
    logic v;
    logic [31:0] cur;
    int n, idx;
    bit r;
    exp_q.delete();
    v = 1'b0; cur = 32'd0; idx = 0; n = 2 + P; exp_loads = 0; exp_done = -1;
    while (idx < NW) begin
      r = ready_of(mode, n);
      if (v && r) begin exp_q.push_back(cur); v = 1'b0; end
      if (board[idx] != 32'd0) begin
        if (!v) begin cur = board[idx]; v = 1'b1; idx++; exp_loads++; end
      end else begin
        idx++;
      end
      n++;
    end
    while (n < MAXC) begin
      r = ready_of(mode, n);
      if (!v || r) begin
        if (v) exp_q.push_back(cur);
        exp_done = n + 1;
        break;
      end
      n++;
    end
  endtask

  task automatic run_pass(input bit color, input int mode, input int abort_n,
                          input int mid_start_n, input int rst_at);
    int n;
    bit r, prev_stall;
    logic [31:0] prev_data;
    clear_cnt = 0; clear_first = -1; en_cnt = 0; en_first = -1; done_cnt = 0;
    done_cyc = -1; stab_viol = 0; end_n = -1; abort_vld = 1'b0; xfers.delete();
    prev_stall = 1'b0; prev_data = 32'd0;
    engine_color = color; start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; n = 1;
    while (n < MAXC) begin
      if (!busy) begin end_n = n; break; end
      if (sq_clear)  begin clear_cnt++; if (clear_first < 0) clear_first = n; end
      if (sq_enable) begin en_cnt++; if (en_first < 0) en_first = n; end
      if (done)      begin done_cnt++; done_cyc = n; end
      if (n == rst_at) begin
        rst = 1'b1; #1;
        rst_snap = {sq_clear, sq_enable, sq_color, busy, done, mv_valid,
                    scan_sq, scan_dir, mv_data, move_count, 1'b0};
        #1 rst = 1'b0;
        end_n = n;
        break;
      end
      r = ready_of(mode, n);
      mv_ready     = r;
      abort        = (n == abort_n);
      start        = (n == mid_start_n);
      engine_color = (n == mid_start_n) ? ~color : color;
      if (n == abort_n) abort_vld = mv_valid;
      if (prev_stall && (!mv_valid || mv_data !== prev_data)) stab_viol++;
      if (mv_valid && r) xfers.push_back(mv_data);
      prev_stall = mv_valid && !r;
      prev_data  = mv_data;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; abort = 1'b0; mv_ready = 1'b1; engine_color = 1'b0;
    if (end_n < 0) begin
      tests++; fails++;
      $display("FAIL run_timeout: busy still high after %0d cycles", MAXC);
    end
  endtask

  task automatic fill_board(input int kind);
    for (int i = 0; i < NW; i++) begin
      case (kind)
        1:       board[i] = $urandom | 32'h1;
        2:       board[i] = ($urandom_range(0, 5) == 0) ? ($urandom | 32'h1) : 32'd0;
        default: board[i] = 32'd0;
      endcase
    end
  endtask

  task automatic test_reset();
    fill_board(0);
    rst = 1'b1; start = 1'b0; abort = 1'b0; engine_color = 1'b0; mv_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({sq_clear, sq_enable, sq_color, mv_valid, busy, done} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 000000",
                        {sq_clear, sq_enable, sq_color, mv_valid, busy, done});
    end
    tests++;
    if ({scan_sq, scan_dir, mv_data, move_count} !== 50'd0) begin
      fails++; $display("FAIL reset_regs: sq=%0d dir=%0d data=%h cnt=%0d expected all 0",
                        scan_sq, scan_dir, mv_data, move_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: busy=%b expected 0", busy); end
  endtask

  task automatic test_empty();
    fill_board(0);
    model_pass(0);
    run_pass(1'b0, 0, -1, -1, -1);
    tests++;
    if (clear_cnt != 1 || clear_first != 1) begin
      fails++; $display("FAIL empty_clear: cnt=%0d first=%0d expected 1/1", clear_cnt, clear_first);
    end
    tests++;
    if (en_cnt != P || en_first != 2) begin
      fails++; $display("FAIL empty_enable: cnt=%0d first=%0d expected %0d/2", en_cnt, en_first, P);
    end
    tests++;
    if (xfers.size() != 0) begin fails++; $display("FAIL empty_xfers: got %0d expected 0", xfers.size()); end
    tests++;
    if (done_cyc != 1035 || done_cnt != 1 || exp_done != 1035) begin
      fails++; $display("FAIL empty_done: cycle=%0d pulses=%0d expected 1035/1", done_cyc, done_cnt);
    end
    tests++;
    if (move_count !== 8'd0 || end_n != 1036) begin
      fails++; $display("FAIL empty_count: cnt=%0d busy_end=%0d expected 0/1036", move_count, end_n);
    end
  endtask

  task automatic test_two_moves();
    fill_board(0);
    board[12*16+3]  = 32'h0000_0C1C;
    board[63*16+15] = 32'h0000_3F2E;
    model_pass(0);
    run_pass(1'b0, 0, -1, -1, -1);
    tests++;
    if (xfers.size() != 2 || xfers[0] !== 32'h0000_0C1C || xfers[1] !== 32'h0000_3F2E) begin
      fails++; $display("FAIL two_xfers: got %0d words expected 0c1c,3f2e", xfers.size());
    end
    tests++;
    if (move_count !== 8'd2 || done_cyc != 1035) begin
      fails++; $display("FAIL two_done: cnt=%0d done=%0d expected 2/1035", move_count, done_cyc);
    end
  endtask

  task automatic check_stream(input string name);
    int bad;
    bad = (xfers.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < xfers.size() && bad == 0; i++)
      if (xfers[i] !== exp_q[i]) bad = i + 2;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL %s_stream: got %0d words expected %0d (first bad idx code %0d)",
                        name, xfers.size(), exp_q.size(), bad);
    end
    tests++;
    if (done_cyc != exp_done || done_cnt != 1) begin
      fails++; $display("FAIL %s_done: cycle=%0d pulses=%0d expected %0d/1", name, done_cyc, done_cnt, exp_done);
    end
    tests++;
    if (stab_viol != 0) begin
      fails++; $display("FAIL %s_stable: %0d stalled-word changes expected 0", name, stab_viol);
    end
    tests++;
    if (move_count !== ((exp_loads > 255) ? 8'd255 : 8'(exp_loads))) begin
      fails++; $display("FAIL %s_count: got %0d expected %0d", name, move_count,
                        (exp_loads > 255) ? 255 : exp_loads);
    end
  endtask

  task automatic test_all_toggle();
    fill_board(1);
    model_pass(1);
    run_pass(1'b0, 1, -1, -1, -1);
    check_stream("toggle");
    tests++;
    if (xfers.size() != NW || move_count !== 8'd255) begin
      fails++; $display("FAIL toggle_sat: xfers=%0d cnt=%0d expected %0d/255", xfers.size(), move_count, NW);
    end
  endtask

  task automatic test_flush_hold();
    fill_board(0);
    board[NW-1] = 32'hDEAD_0001;
    model_pass(2);
    run_pass(1'b0, 2, -1, -1, -1);
    check_stream("flush");
    tests++;
    if (done_cyc != 1055) begin
      fails++; $display("FAIL flush_delay: done=%0d expected 1055", done_cyc);
    end
  endtask

  task automatic test_abort();
    fill_board(1);
    run_pass(1'b0, 0, 2 + P + 99, -1, -1);
    tests++;
    if (abort_vld !== 1'b1 || end_n != 3 + P + 99) begin
      fails++; $display("FAIL abort_idle: vld_at_abort=%b busy_end=%0d expected 1/%0d", abort_vld, end_n, 3 + P + 99);
    end
    tests++;
    if (mv_valid !== 1'b0 || done_cnt != 0 || move_count !== 8'd99) begin
      fails++; $display("FAIL abort_state: vld=%b done=%0d cnt=%0d expected 0/0/99", mv_valid, done_cnt, move_count);
    end
    fill_board(0);
    run_pass(1'b0, 0, -1, -1, -1);
    tests++;
    if (move_count !== 8'd0 || done_cyc != 1035) begin
      fails++; $display("FAIL abort_restart: cnt=%0d done=%0d expected 0/1035", move_count, done_cyc);
    end
  endtask

  task automatic test_rst_prop();
    fill_board(1);
    run_pass(1'b1, 0, -1, -1, 5);
    tests++;
    if (rst_snap !== 63'd0) begin fails++; $display("FAIL rst_prop: outputs %h expected 0", rst_snap); end
  endtask

  task automatic test_start_ignored();
    fill_board(0);
    run_pass(1'b1, 0, -1, 500, -1);
    tests++;
    if (sq_color !== 1'b1 || done_cyc != 1035 || clear_cnt != 1) begin
      fails++; $display("FAIL start_ignored: color=%b done=%0d clears=%0d expected 1/1035/1",
                        sq_color, done_cyc, clear_cnt);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      fill_board(2);
      for (int i = 0; i < 4096; i++) rdy_tab[i] = ($urandom_range(0, 2) != 0);
      model_pass(3);
      run_pass(s[0], 3, -1, -1, -1);
      check_stream("random");
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_two_moves();
    test_all_toggle();
    test_flush_hold();
    test_abort();
    test_rst_prop();
    test_start_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/movegen_sequencer.md
# movegen_sequencer

Controller for the per-square move-generation array: on a start request it clears all squares, enables ray/knight propagation for a fixed number of cycles, then scans every square's per-direction move word through an external address-selected mux. It serialises the non-zero move words onto a single valid/ready stream toward the search logic. It is the only driver of the array's shared clear, enable and engine-colour lines.

## Interface
- PROP_CYCLES, 8, cycles `sq_enable` is held high for propagation (≥1)
- NUM_SQ, 64, squares scanned (≥1)
- NUM_DIR, 16, move words per square: 8 slide + 8 knight (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a generation pass; honoured only in IDLE
- abort  in  1  synchronous; from any non-IDLE state, return to IDLE next cycle
- engine_color  in  1  side to move; latched when start is honoured
- sq_clear  out  1  array clear strobe
- sq_enable  out  1  array propagation enable
- sq_color  out  1  latched engine colour to the array
- scan_sq  out  clog2(NUM_SQ)  square index to the external move mux
- scan_dir  out  clog2(NUM_DIR)  direction index to the external move mux
- scan_move  in  32  move word selected by scan_sq/scan_dir, combinational; 32'd0 = no move
- mv_valid  out  1  mv_data holds a move
- mv_ready  in  1  consumer accepts the move when high with mv_valid
- mv_data  out  32  move word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a completed pass
- move_count  out  8  moves emitted this pass, saturating at 255

## Operation
- Reset values: state IDLE; all outputs 0; scan_sq = scan_dir = 0; sq_color 0.
- IDLE: start=1 → CLEAR. On this transition, latch sq_color ← engine_color and clear move_count to 0.
- CLEAR: sq_clear=1 for exactly 1 cycle → PROP.
- PROP: sq_enable=1 for exactly PROP_CYCLES cycles. Then reset scan_sq and scan_dir to 0 → SCAN.
- SCAN: address = (scan_sq, scan_dir). Each cycle, evaluate scan_move:
  - scan_move == 0: advance.
  - scan_move != 0 and the output slot is free (mv_valid=0, or mv_ready=1 this cycle): load mv_data, set mv_valid=1, increment move_count (saturating), advance.
  - scan_move != 0 and the slot is occupied: stall, hold the address.
- Advance: scan_dir+1. When scan_dir = NUM_DIR-1, scan_dir ← 0 and scan_sq+1.
- Handling address (NUM_SQ-1, NUM_DIR-1) → FLUSH instead of advancing.
- FLUSH: stay until mv_valid=0, or mv_valid & mv_ready this cycle → DONE.
- DONE: done=1 for 1 cycle → IDLE. move_count and sq_color hold until the next honoured start.
- Output stream:
  - mv_valid clears on mv_ready unless a new word loads in the same cycle.
  - mv_data is stable while mv_valid & !mv_ready.
- sq_enable=0 outside PROP; sq_clear=0 outside CLEAR.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- abort, any non-IDLE state: next cycle state IDLE, mv_valid=0, sq_enable=sq_clear=0, no done pulse; move_count holds.
- rst mid-pass: immediate return to reset values.

## Timing
- start sampled at edge k:
  - CLEAR during cycle k+1.
  - PROP during cycles k+2 … k+1+PROP_CYCLES.
  - SCAN starts at k+2+PROP_CYCLES.
- Unstalled SCAN takes exactly NUM_SQ·NUM_DIR cycles. FLUSH takes ≥1 cycle.
- Minimum start-to-done: done high in cycle k+3+PROP_CYCLES+NUM_SQ·NUM_DIR (k+1035 at defaults). Each stall cycle adds 1.
- Move loaded in cycle t → mv_valid high from cycle t+1.
- Throughput: 1 move/cycle while mv_ready=1.
- busy rises the cycle after start is sampled and falls the cycle after done.

## Test plan
- Empty board (scan_move always 0), mv_ready=1, defaults → sq_clear high 1 cycle, sq_enable high 8 cycles, no mv_valid, done in cycle k+1035, move_count=0.
- Non-zero scan_move only at (sq 12, dir 3)=32'h0000_0C1C and (sq 63, dir 15)=32'h0000_3F2E, mv_ready=1 → exactly two transfers in scan order, move_count=2, done unchanged at k+1035.
- Every scan_move non-zero, mv_ready toggling 1/0 each cycle → 1024 transfers, no loss or duplication, mv_data stable while stalled, move_count=255 (saturated), done delayed by the stall count.
- Last word non-zero, mv_ready held 0 for 20 cycles → FLUSH holds, mv_valid stays high, done 1 cycle after mv_ready rises.
- abort asserted at the 100th SCAN cycle with mv_valid=1 → IDLE next cycle, mv_valid=0, busy=0, no done; a following start begins a normal pass with move_count reset.
- rst during PROP → all outputs 0 immediately; start during busy and start with engine_color=1 → busy-time start ignored, sq_color=1 latched for the honoured pass.
